// File: rtl/display_pkg.sv
// Shared constants and types for the display buffer and the VGA stage it feeds.
package display_pkg;

    localparam int unsigned DEPTH = 65;
    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 7;

    // Highest legal write address; anything above it is dropped and flagged.
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    // Byte bank, also the type of the VGA stage's ram input.
    typedef logic [DEPTH-1:0][DW-1:0] bank_t;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StPending,
        StSwap
    } state_e;

endpackage

// File: rtl/vsync_edge.sv
// Synchronizes the asynchronous active-low vsync and emits a one-cycle frame_start
// pulse on its falling edge. All flops preset to the vsync idle level.
module vsync_edge (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    output logic frame_start
);

    logic sync1;
    logic sync2;
    logic sync_prev;

    // Two-stage synchronizer plus one history flop for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync1     <= vsync;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign frame_start = sync_prev & ~sync2;

endmodule

// File: rtl/display_buffer.sv
// Double-buffered byte array for the VGA stage: writes land in a shadow bank and
// are published to the front bank in one cycle at the next frame start.
module display_buffer
    import display_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          clear_req,
    input  logic          commit_req,
    input  logic          vsync,
    output bank_t         ram,
    output logic          commit_pending,
    output logic          addr_err,
    output logic [7:0]    frame_cnt
);

    state_e        state;
    logic [AW-1:0] clr_idx;
    bank_t         shadow;
    bank_t         front;
    logic          frame_start;
    logic          wr_fire;
    logic          addr_ok;

    vsync_edge u_vsync_edge (
        .clk         (clk),
        .reset       (reset),
        .vsync       (vsync),
        .frame_start (frame_start)
    );

    // wr_ready is only ever high in IDLE, so a fire implies the IDLE state.
    assign wr_fire = wr_valid & wr_ready;
    assign addr_ok = (wr_addr <= LAST_IDX);
    assign ram     = front;

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= StIdle;
            clr_idx        <= '0;
            wr_ready       <= 1'b0;
            commit_pending <= 1'b0;
            addr_err       <= 1'b0;
            frame_cnt      <= 8'd0;
        end else begin
            unique case (state)
                StIdle: begin
                    wr_ready <= 1'b1;
                    if (wr_fire && !addr_ok) begin
                        addr_err <= 1'b1;
                    end
                    if (clear_req) begin
                        state          <= StClear;
                        clr_idx        <= '0;
                        wr_ready       <= 1'b0;
                        addr_err       <= 1'b0;
                        commit_pending <= commit_req;
                    end else if (commit_req) begin
                        state          <= StPending;
                        wr_ready       <= 1'b0;
                        commit_pending <= 1'b1;
                    end
                end
                StClear: begin
                    // commit_pending doubles as the latched commit request.
                    if (commit_req) begin
                        commit_pending <= 1'b1;
                    end
                    if (clr_idx == LAST_IDX) begin
                        if (commit_pending || commit_req) begin
                            state <= StPending;
                        end else begin
                            state    <= StIdle;
                            wr_ready <= 1'b1;
                        end
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                StPending: begin
                    if (frame_start) begin
                        state <= StSwap;
                    end
                end
                StSwap: begin
                    frame_cnt      <= frame_cnt + 8'd1;
                    commit_pending <= 1'b0;
                    wr_ready       <= 1'b1;
                    state          <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    // Shadow bank: sequential clear has priority; writes only arrive in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow <= '0;
        end else if (state == StClear) begin
            shadow[clr_idx] <= '0;
        end else if (wr_fire && addr_ok) begin
            shadow[wr_addr] <= wr_data;
        end
    end

    // Front bank: whole-array copy in the single SWAP cycle only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            front <= '0;
        end else if (state == StSwap) begin
            front <= shadow;
        end
    end

endmodule
